link_tx_scheduler: RTL and testbench

- Shares the single FPGA-to-FPGA transmit sender between N_REQ local requesters, using round-robin arbitration.
- Per transfer: latches the winner's word count, pulses the sender start, supervises completion with a watchdog, and retries on timeout up to a limit.
- Sits between the requester FIFOs and the sender. It drives the sender's start, send-count and source select, and consumes the sender's done.

---
 rtl/link_tx_scheduler_if.sv | 29 ++
 rtl/link_tx_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_link_tx_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_tx_scheduler_if.sv
// Requester/sender-side bundle for link_tx_scheduler.
// The scheduler connects through slave; the requester FIFOs and sender side use master.
interface link_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [10*N_REQ-1:0] len;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    cmpl;
  logic [N_REQ-1:0]    err;
  logic [SEL_W-1:0]    sel;
  logic                snd_start;
  logic [9:0]          snd_count;
  logic                snd_abort;
  logic                snd_done;
  logic                busy;

  modport master (
    output req, len, snd_done,
    input  grant, cmpl, err, sel, snd_start, snd_count, snd_abort, busy
  );

  modport slave (
    input  req, len, snd_done,
    output grant, cmpl, err, sel, snd_start, snd_count, snd_abort, busy
  );
endinterface

// File: rtl/link_tx_scheduler.sv
// Round-robin scheduler sharing one link transmit sender between N_REQ requesters,
// with start/watchdog/retry supervision. Define LINK_SCHED_STATS_EN for statistics counters.
module link_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_LEN   = 512,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int GAP       = 16
) (
  input  logic               clk,
  input  logic               rst,
  link_tx_scheduler_if.slave bus
`ifdef LINK_SCHED_STATS_EN
  ,
  output logic [15:0]        stat_xfers,
  output logic [15:0]        stat_timeouts,
  output logic [15:0]        stat_errs,
  input  logic               stat_clr
`endif
);

  localparam int SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [10:0]      LEN_LIMIT = 11'(MAX_LEN);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT_DONE,
    S_GAP_WAIT,
    S_FINISH
  } state_t;

  state_t             state_reg;
  logic [SEL_W-1:0]   ptr_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [N_REQ-1:0]   cmpl_reg;
  logic [N_REQ-1:0]   err_reg;
  logic               start_reg;
  logic               abort_reg;
  logic [9:0]         count_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [RTY_W-1:0]   retry_reg;

  // Per-requester word-count slices of the packed len bus.
  logic [9:0] len_slice [N_REQ];
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_len
    assign len_slice[gi] = bus.len[10*gi +: 10];
  end

  // Round-robin pick: first set request searching upward from ptr_reg+1 with wrap.
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;

  always_comb begin
    cand       = ptr_reg;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot = ONE_HOT0 << pick_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ptr_reg   <= LAST_IDX;
      sel_reg   <= '0;
      grant_reg <= '0;
      cmpl_reg  <= '0;
      err_reg   <= '0;
      start_reg <= 1'b0;
      abort_reg <= 1'b0;
      count_reg <= '0;
      timer_reg <= '0;
      retry_reg <= '0;
    end else begin
      cmpl_reg  <= '0;
      err_reg   <= '0;
      start_reg <= 1'b0;
      abort_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_onehot;
            sel_reg   <= pick_idx;
            count_reg <= len_slice[pick_idx];
            state_reg <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (count_reg == '0) begin
            cmpl_reg  <= grant_reg;
            state_reg <= S_FINISH;
          end else if ({1'b0, count_reg} > LEN_LIMIT) begin
            err_reg   <= grant_reg;
            state_reg <= S_FINISH;
          end else begin
            start_reg <= 1'b1;
            timer_reg <= '0;
            state_reg <= S_START;
          end
        end

        // The start cycle counts toward the watchdog, so the abort lands
        // exactly TIMEOUT cycles after the start pulse.
        S_START: begin
          timer_reg <= timer_reg + 1'b1;
          state_reg <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          timer_reg <= timer_reg + 1'b1;
          if (bus.snd_done) begin
            cmpl_reg  <= grant_reg;
            state_reg <= S_FINISH;
          end else if (timer_reg >= TO_LAST) begin
            abort_reg <= 1'b1;
            if (retry_reg < RTY_LIMIT) begin
              retry_reg <= retry_reg + 1'b1;
              timer_reg <= '0;
              state_reg <= S_GAP_WAIT;
            end else begin
              err_reg   <= grant_reg;
              state_reg <= S_FINISH;
            end
          end
        end

        // Timer is reused as the inter-attempt gap counter.
        S_GAP_WAIT: begin
          if (timer_reg >= GAP_LAST) begin
            start_reg <= 1'b1;
            timer_reg <= '0;
            state_reg <= S_START;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_FINISH: begin
          grant_reg <= '0;
          ptr_reg   <= sel_reg;
          retry_reg <= '0;
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.cmpl      = cmpl_reg;
  assign bus.err       = err_reg;
  assign bus.sel       = sel_reg;
  assign bus.snd_start = start_reg;
  assign bus.snd_abort = abort_reg;
  assign bus.snd_count = count_reg;
  assign bus.busy      = (state_reg != S_IDLE);

`ifdef LINK_SCHED_STATS_EN
  logic [15:0] xfers_reg;
  logic [15:0] timeouts_reg;
  logic [15:0] errs_reg;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      xfers_reg    <= '0;
      timeouts_reg <= '0;
      errs_reg     <= '0;
    end else begin
      if (|cmpl_reg && xfers_reg != 16'hFFFF)
        xfers_reg <= xfers_reg + 16'd1;
      if (abort_reg && timeouts_reg != 16'hFFFF)
        timeouts_reg <= timeouts_reg + 16'd1;
      if (|err_reg && errs_reg != 16'hFFFF)
        errs_reg <= errs_reg + 16'd1;
    end
  end

  assign stat_xfers    = xfers_reg;
  assign stat_timeouts = timeouts_reg;
  assign stat_errs     = errs_reg;
`endif

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_reg));
  a_cmpl_err_excl: assert property (@(posedge clk) disable iff (rst) !(|cmpl_reg && |err_reg));

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Scoreboard bench for link_tx_scheduler: expected transfers are queued at stimulus time
// and retired by a monitor when cmpl/err fires; includes a small sender model.
module tb_link_tx_scheduler;
  localparam int N_REQ     = 4;
  localparam int MAX_LEN   = 512;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 3;
  localparam int GAP       = 16;

  typedef struct {
    int sel;
    int count;
    bit is_err;
    int starts;
    int aborts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  link_tx_scheduler_if #(.N_REQ(N_REQ)) bus();

`ifdef LINK_SCHED_STATS_EN
  logic [15:0] stat_xfers;
  logic [15:0] stat_timeouts;
  logic [15:0] stat_errs;
  logic        stat_clr = 1'b0;
`endif

  link_tx_scheduler #(
    .N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LINK_SCHED_STATS_EN
    ,
    .stat_xfers(stat_xfers),
    .stat_timeouts(stat_timeouts),
    .stat_errs(stat_errs),
    .stat_clr(stat_clr)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   xfers = 0;
  int   done_delay = 0;
  int   skip_starts = 0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sender model: answers the Nth start (after skip_starts ignored) with a
  // one-cycle snd_done done_delay cycles later; done_delay 0 means never.
  initial begin
    int done_cnt;
    done_cnt = 0;
    bus.snd_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.snd_done = 1'b0;
      if (rst) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) bus.snd_done = 1'b1;
        end
        if (bus.snd_start) begin
          if (skip_starts > 0) skip_starts--;
          else if (done_delay > 0) done_cnt = done_delay;
        end
      end
    end
  end

  // Monitor: checks timing of starts/aborts and retires scoreboard entries.
  initial begin
    int cyc, grant_cyc, last_start, last_abort, n_st, n_ab;
    bit fall_pending;
    logic [N_REQ-1:0] prev_grant;
    exp_t e;
    cyc = 0; grant_cyc = 0; last_start = 0; last_abort = 0; n_st = 0; n_ab = 0;
    fall_pending = 1'b0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_grant   = '0;
        fall_pending = 1'b0;
        n_st = 0;
        n_ab = 0;
      end else begin
        if (fall_pending) begin
          check_eq("grant_fall", bus.grant, 0);
          check_eq("busy_idle", bus.busy, 0);
          fall_pending = 1'b0;
        end
        if (bus.grant != '0 && prev_grant == '0) begin
          check_eq("grant_onehot", $onehot(bus.grant), 1);
          grant_cyc = cyc;
          n_st = 0;
          n_ab = 0;
        end
        if (bus.snd_start) begin
          n_st++;
          if (n_st == 1) check_eq("start_after_grant", cyc - grant_cyc, 1);
          else           check_eq("restart_gap", cyc - last_abort, GAP);
          if (sb.size() > 0) check_eq("snd_count", bus.snd_count, sb[0].count);
          last_start = cyc;
        end
        if (bus.snd_abort) begin
          n_ab++;
          check_eq("abort_time", cyc - last_start, TIMEOUT);
          last_abort = cyc;
        end
        if (bus.cmpl != '0 || bus.err != '0) begin
          check_eq("cmpl_err_excl", (bus.cmpl != '0) && (bus.err != '0), 0);
          if (sb.size() == 0) begin
            check_eq("sb_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            check_eq("sel", bus.sel, e.sel);
            check_eq("pulse", e.is_err ? bus.err : bus.cmpl, 1 << e.sel);
            check_eq("other_pulse", e.is_err ? bus.cmpl : bus.err, 0);
            check_eq("grant_hold", bus.grant, 1 << e.sel);
            check_eq("starts", n_st, e.starts);
            check_eq("aborts", n_ab, e.aborts);
            $display("xfer %0d: req=%0d len=%0d %s starts=%0d aborts=%0d", xfers, e.sel,
                     e.count, e.is_err ? "err" : "cmpl", n_st, n_ab);
          end
          xfers++;
          fall_pending = 1'b1;
        end
        prev_grant = bus.grant;
      end
    end
  end

  task automatic wait_xfers(input int target, input int budget);
    int k;
    k = 0;
    while (xfers < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("xfer_wait", xfers >= target, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, bus.grant, 0);
    check_eq({tag, "_cmpl"}, bus.cmpl, 0);
    check_eq({tag, "_err"}, bus.err, 0);
    check_eq({tag, "_sel"}, bus.sel, 0);
    check_eq({tag, "_start"}, bus.snd_start, 0);
    check_eq({tag, "_count"}, bus.snd_count, 0);
    check_eq({tag, "_abort"}, bus.snd_abort, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic push_exp(input int k, input int lenv, input bit is_err, input int st, input int ab);
    exp_t e;
    e.sel = k; e.count = lenv; e.is_err = is_err; e.starts = st; e.aborts = ab;
    sb.push_back(e);
  endtask

  task automatic run_one(input int k, input int lenv, input int dly, input int skip,
                         input bit is_err, input int st, input int ab);
    int target;
    done_delay  = dly;
    skip_starts = skip;
    bus.len[10*k +: 10] = lenv[9:0];
    push_exp(k, lenv, is_err, st, ab);
    target  = xfers + 1;
    bus.req = N_REQ'(1 << k);
    wait_xfers(target, 1000);
    bus.req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int target;
    bus.req = '0;
    bus.len = '0;
    do_reset();

    // Single transfer: req seen in IDLE, CHECK next, start in the third cycle.
    done_delay = 50;
    bus.len[9:0] = 10'd100;
    push_exp(0, 100, 1'b0, 1, 0);
    target  = xfers + 1;
    bus.req = 4'b0001;
    @(negedge clk);
    check_eq("t1_grant", bus.grant, 1);
    check_eq("t1_busy", bus.busy, 1);
    @(negedge clk);
    check_eq("t1_start", bus.snd_start, 1);
    check_eq("t1_count", bus.snd_count, 100);
    wait_xfers(target, 1000);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Fairness from a fresh pointer: 0,1,2,3,0.
    do_reset();
    done_delay = 10;
    bus.len = {10'd44, 10'd33, 10'd22, 10'd11};
    push_exp(0, 11, 1'b0, 1, 0);
    push_exp(1, 22, 1'b0, 1, 0);
    push_exp(2, 33, 1'b0, 1, 0);
    push_exp(3, 44, 1'b0, 1, 0);
    push_exp(0, 11, 1'b0, 1, 0);
    target  = xfers + 5;
    bus.req = 4'b1111;
    wait_xfers(target, 2000);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Length boundaries.
    run_one(1, 0,   5, 0, 1'b0, 0, 0);
    run_one(1, 600, 5, 0, 1'b1, 0, 0);
    run_one(1, 513, 5, 0, 1'b1, 0, 0);
    run_one(1, 512, 5, 0, 1'b0, 1, 0);

    // Watchdog: all attempts time out, then retry with success on third attempt.
    run_one(2, 7, 0, 0, 1'b1, 4, 4);
    run_one(2, 8, 5, 2, 1'b0, 3, 2);

    // Done in the exact timeout cycle wins over the abort.
    run_one(1, 3, TIMEOUT - 1, 0, 1'b0, 1, 0);

    // Reset mid-WAIT_DONE: outputs clear and pointer returns to N_REQ-1.
    done_delay  = 0;
    skip_starts = 0;
    bus.len[39:30] = 10'd5;
    bus.req = 4'b1000;
    for (int i = 0; i < 20 && !bus.snd_start; i++) @(negedge clk);
    check_eq("t7_started", bus.snd_start, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    bus.req = 4'b1001;
    bus.len[9:0] = 10'd9;
    done_delay = 5;
    push_exp(0, 9, 1'b0, 1, 0);
    target = xfers + 1;
    rst = 1'b0;
    wait_xfers(target, 1000);
    bus.req = '0;
    repeat (3) @(negedge clk);

`ifdef LINK_SCHED_STATS_EN
    do_reset();
    check_eq("stat_xfers_rst", stat_xfers, 0);
    check_eq("stat_timeouts_rst", stat_timeouts, 0);
    check_eq("stat_errs_rst", stat_errs, 0);
    run_one(0, 4, 5, 2, 1'b0, 3, 2);
    run_one(1, 4, 5, 0, 1'b0, 1, 0);
    run_one(2, 4, 5, 0, 1'b0, 1, 0);
    check_eq("stat_xfers", stat_xfers, 3);
    check_eq("stat_timeouts", stat_timeouts, 2);
    check_eq("stat_errs", stat_errs, 0);
    run_one(3, 700, 5, 0, 1'b1, 0, 0);
    check_eq("stat_errs_one", stat_errs, 1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check_eq("stat_xfers_clr", stat_xfers, 0);
    check_eq("stat_timeouts_clr", stat_timeouts, 0);
    check_eq("stat_errs_clr", stat_errs, 0);
`endif

    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
